// File: rtl/flash_pkg.sv
// flash_pkg: read-FSM state type and parameter-derived width helpers for the flash burst reader
package flash_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, FILL} flash_rd_state_t;
  function automatic int bsel_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction
  function automatic int wsel_w(input int burst_len);
    return $clog2(burst_len);
  endfunction
endpackage

// File: rtl/flash_line_buffer.sv
// flash_line_buffer: one cache line of flash words, single write port, combinational byte read
module flash_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN = 4,
  parameter int IW = 2,
  parameter int BW = 2
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IW-1:0]         rd_idx,
  input  logic [BW-1:0]         rd_bsel,
  output logic [7:0]            rd_byte
);
  logic [DATA_WIDTH-1:0] mem [BURST_LEN];
  always_ff @(posedge clock)
    if (wr_en) mem[wr_idx] <= wr_data;
  assign rd_byte = mem[rd_idx][{rd_bsel, 3'b000} +: 8];
endmodule

// File: rtl/flash_burst_reader.sv
// flash_burst_reader: byte read front-end for the UFM data port, one-line buffer refilled by a single burst
module flash_burst_reader
  import flash_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_WIDTH = 4,
  parameter int BURST_LEN = 4,
  localparam int BSEL = bsel_w(DATA_WIDTH),
  localparam int WSEL = wsel_w(BURST_LEN)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [ADDR_WIDTH+BSEL-1:0] req_addr,
  output logic                       req_ready,
  output logic                       rsp_valid,
  output logic [7:0]                 rsp_data,
  input  logic                       invalidate,
  output logic [ADDR_WIDTH-1:0]      avm_addr,
  output logic                       avm_read,
  output logic [BURST_WIDTH-1:0]     avm_burstcount,
  input  logic [DATA_WIDTH-1:0]      avm_readdata,
  input  logic                       avm_waitrequest,
  input  logic                       avm_readdatavalid
);
  localparam int CW = WSEL > 0 ? WSEL : 1;
  localparam int BW = BSEL > 0 ? BSEL : 1;
  localparam int TW = ADDR_WIDTH - WSEL;
  localparam int RW = ADDR_WIDTH + BSEL;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BURST_LEN - 1);
  localparam logic [RW-1:0] BSEL_MASK = RW'(DATA_WIDTH / 8 - 1);
  flash_rd_state_t state;
  logic [TW-1:0] tag;
  logic line_valid, inv_pend, hit;
  logic [CW-1:0] beat_cnt, off_q, req_off;
  logic [BW-1:0] bsel_q, req_bsel;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [7:0] buf_byte, beat_byte;
  assign req_word = req_addr[RW-1:BSEL];
  assign req_off = CW'(req_word & OFF_MASK);
  assign req_bsel = BW'(req_addr & BSEL_MASK);
  assign hit = line_valid && !invalidate && tag == req_word[ADDR_WIDTH-1:WSEL];
  assign beat_byte = avm_readdata[{bsel_q, 3'b000} +: 8];
  assign req_ready = state == IDLE;
  assign avm_burstcount = BURST_WIDTH'(BURST_LEN);
  flash_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN(BURST_LEN),
    .IW(CW),
    .BW(BW)
  ) u_line (
    .clock(clock),
    .wr_en(state == FILL && avm_readdatavalid),
    .wr_idx(beat_cnt),
    .wr_data(avm_readdata),
    .rd_idx(req_off),
    .rd_bsel(req_bsel),
    .rd_byte(buf_byte)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tag <= '0;
      line_valid <= 1'b0;
      inv_pend <= 1'b0;
      beat_cnt <= '0;
      off_q <= '0;
      bsel_q <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      avm_read <= 1'b0;
      avm_addr <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (invalidate) line_valid <= 1'b0;
          if (req_valid && hit) begin
            rsp_data <= buf_byte;
            rsp_valid <= 1'b1;
          end else if (req_valid) begin
            off_q <= req_off;
            bsel_q <= req_bsel;
            tag <= req_word[ADDR_WIDTH-1:WSEL];
            line_valid <= 1'b0;
            inv_pend <= 1'b0;
            avm_addr <= req_word & ~OFF_MASK;
            avm_read <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (invalidate) inv_pend <= 1'b1;
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state <= FILL;
          end
        end
        FILL: begin
          if (invalidate) inv_pend <= 1'b1;
          if (avm_readdatavalid) begin
            beat_cnt <= beat_cnt == LAST ? '0 : beat_cnt + 1'b1;
            if (beat_cnt == off_q) begin
              rsp_data <= beat_byte;
              rsp_valid <= 1'b1;
            end
            // an invalidate on the final beat still counts as during the fill
            if (beat_cnt == LAST) begin
              line_valid <= !(inv_pend || invalidate);
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/flash_burst_reader.md
# flash_burst_reader

Parametrised read front-end for the on-chip user flash (UFM) data port. It accepts single-byte read requests from the CPU-socket bus logic and serves them from a one-line buffer. On a miss it refills the line with one Avalon-MM burst, returning the requested byte as soon as its word arrives (critical-word-first response, in-order fill). It sits between the socket address decoder and the flash IP's data port; the CSR port is not touched.

## Interface

- `ADDR_WIDTH`, 12: flash word address width (Avalon-MM data address).
- `DATA_WIDTH`, 32: flash word width; multiple of 8, power of two.
- `BURST_WIDTH`, 4: width of `avm_burstcount`.
- `BURST_LEN`, 4: words per line/burst; power of two, `BURST_LEN < 2**BURST_WIDTH`.
- Derived: `BSEL = log2(DATA_WIDTH/8)`, `WSEL = log2(BURST_LEN)`.

Ports:

- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-high; shared with the flash IP.
- `req_valid` in 1: byte read request.
- `req_addr` in `ADDR_WIDTH+BSEL`: byte address.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `rsp_valid` out 1: one-cycle pulse, `rsp_data` valid.
- `rsp_data` out 8: returned byte.
- `invalidate` in 1: discard buffered line.
- `avm_addr` out `ADDR_WIDTH`: burst start word address, line-aligned.
- `avm_read` out 1: burst read command.
- `avm_burstcount` out `BURST_WIDTH`: constant `BURST_LEN`.
- `avm_readdata` in `DATA_WIDTH`: burst beat data.
- `avm_waitrequest` in 1: command stall.
- `avm_readdatavalid` in 1: beat strobe.

## Operation

- States: `IDLE`, `ISSUE`, `FILL`. `req_ready = (state == IDLE)`.
- Line state: `tag` (upper `ADDR_WIDTH-WSEL` bits of the word address), `line_valid`, and `BURST_LEN` data words.
- **Request in `IDLE`, hit** (`line_valid`, tag match, no `invalidate` this cycle):
  - Register the selected byte into `rsp_data` and pulse `rsp_valid`.
  - Stay in `IDLE`.
- **Request in `IDLE`, miss:**
  - Latch word offset and byte select.
  - Load `tag`; clear `line_valid`.
  - `avm_addr = {tag, WSEL'b0}`; go to `ISSUE`.
- **`ISSUE`:**
  - `avm_read` = 1.
  - Held with `avm_addr` stable while `avm_waitrequest` = 1.
  - Go to `FILL` on the first cycle with `avm_waitrequest` = 0.
- **`FILL`:**
  - Each `avm_readdatavalid` writes `avm_readdata` into word `beat_cnt`, then `beat_cnt++`.
  - When `beat_cnt` equals the latched word offset, the byte is also registered to `rsp_data` and `rsp_valid` pulses.
  - On the beat with `beat_cnt == BURST_LEN-1`: return to `IDLE` and set `line_valid` unless an invalidate occurred during the fill.
- **Byte select:** little-endian; byte k = word[8k+7:8k].
- **`invalidate` rules:**
  - In `IDLE`, clears `line_valid`.
  - During `ISSUE`/`FILL`, sets a sticky `inv_pend`; the fill completes but leaves `line_valid` = 0.
  - In `IDLE`, simultaneous with a request: invalidate wins and the request is a miss.
- **`req_valid` while `req_ready` = 0:** ignored; the requester holds it.
- **Reset values:** `state` = `IDLE`, `req_ready` = 1, `rsp_valid` = 0, `rsp_data` = 0, `avm_read` = 0, `avm_addr` = 0, `line_valid` = 0, `beat_cnt` = 0, `inv_pend` = 0.
- **Reset mid-burst:** abandons the burst. No drain is required because the flash IP shares `reset`.

## Timing

- **Hit:** accepted on edge N, `rsp_valid` high in cycle N+1 for exactly one cycle.
- **Miss:**
  - Accepted on edge N; `avm_read` high from cycle N+1.
  - Command completes on the first edge with `avm_waitrequest` = 0.
  - `rsp_valid` in the cycle after the beat carrying the requested word.
  - `req_ready` high in the cycle after the final beat.
- **Back-to-back hits:** one request per cycle, one response per cycle.
- `avm_read` is registered and never asserted outside `ISSUE`.
- `avm_readdatavalid` outside `FILL` is ignored.
- `beat_cnt` is `WSEL` bits wide (1 bit when `BURST_LEN` = 1) and wraps to 0 at the end of a fill.

## Structure

- Package `flash_pkg`:
  - State enum `flash_rd_state_t`.
  - Parameter-derived widths `BSEL` and `WSEL` (as clog2 functions).
- Sub-module `flash_line_buffer`:
  - `BURST_LEN` x `DATA_WIDTH` register array.
  - One write port (index, data, enable) and a combinational byte-read port (word index, byte select).
  - The FSM, tag and counters stay in `flash_burst_reader`.

## Test plan

Defaults, `BURST_LEN` = 4, `DATA_WIDTH` = 32.

- **Cold miss:**
  - Stimulus: after reset, request 0x0005; slave waitrequest 2 cycles; beats 0x11223344, 0xAABBCCDD, 0x55667788, 0x99000011.
  - Required: `avm_addr` = 0x000, burstcount = 4, `rsp_data` = 0xCC the cycle after beat 2, `req_ready` = 1 after beat 4.
- **Hit after fill:**
  - Stimulus: request 0x000F.
  - Required: `rsp_data` = 0x99 in the next cycle, no `avm_read`; back-to-back 0x0000, 0x0004 give 0x44, 0xDD on consecutive cycles.
- **Miss to new line:**
  - Stimulus: request 0x0012.
  - Required: `avm_addr` = 0x004, response is byte 2 of beat 1.
- **Invalidate during `FILL`:**
  - Stimulus: pulse `invalidate` at beat 1, then request 0x0000 after the fill.
  - Required: a new burst is issued to 0x000.
- **Simultaneous invalidate and hit-address request in `IDLE`:**
  - Required: treated as a miss; `avm_read` asserted the next cycle.
- **Reset asserted mid-`FILL`:**
  - Required: all outputs at reset values immediately; the next request issues a fresh full burst and returns correct data.
